// File: rtl/if_stage_prefetch_pkg.sv
// Shared constants for the prefetching instruction-fetch stage.
// Also holds the helper that sizes the FIFO occupancy counter.
package if_stage_prefetch_pkg;

    localparam int WORD_WIDTH = 32;

    localparam int                    IF_FIFO_DEPTH = 4;
    localparam logic [WORD_WIDTH-1:0] IF_ADDR_STEP  = WORD_WIDTH'(1);
    localparam logic [WORD_WIDTH-1:0] IF_RESET_PC   = '0;

    // The counter must hold the value DEPTH itself, so it needs one bit more than a pointer.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/if_stage_prefetch_if.sv
// Bus bundle between the fetch stage, instruction memory, EXE redirect logic and ID.
// Handshake: an entry leaves the stage in a cycle with out_valid=1, Freeze=0 and Branch_Taken=0; imem_rdata answers imem_req one cycle later.
interface if_stage_prefetch_if #(
    parameter int WORD_WIDTH = if_stage_prefetch_pkg::WORD_WIDTH,
    parameter int FIFO_DEPTH = if_stage_prefetch_pkg::IF_FIFO_DEPTH
);
    localparam int CW = if_stage_prefetch_pkg::count_width(FIFO_DEPTH);

    logic                  Freeze;
    logic                  Branch_Taken;
    logic [WORD_WIDTH-1:0] Branch_Address;
    logic                  imem_req;
    logic [WORD_WIDTH-1:0] imem_addr;
    logic [WORD_WIDTH-1:0] imem_rdata;
    logic                  out_valid;
    logic [WORD_WIDTH-1:0] PC_Stage_out;
    logic [WORD_WIDTH-1:0] instruction;
    logic [CW-1:0]         fifo_count;

    modport master (
        input  Freeze, Branch_Taken, Branch_Address, imem_rdata,
        output imem_req, imem_addr, out_valid, PC_Stage_out, instruction, fifo_count
    );

    modport slave (
        output Freeze, Branch_Taken, Branch_Address, imem_rdata,
        input  imem_req, imem_addr, out_valid, PC_Stage_out, instruction, fifo_count
    );

endinterface

// File: rtl/if_stage_prefetch_fetch_fifo.sv
// Synchronous prefetch FIFO holding {next_pc, instruction} entries.
// Flush beats push and pop; the caller never pushes when full nor pops when empty.
module fetch_fifo
    import if_stage_prefetch_pkg::*;
#(
    parameter int ENTRY_W = 2 * WORD_WIDTH,
    parameter int DEPTH   = IF_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [ENTRY_W-1:0]       push_data,
    output logic [ENTRY_W-1:0]       head_data,
    output logic [count_width(DEPTH)-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = count_width(DEPTH);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;

    assign head_data = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/if_stage_prefetch.sv
// Prefetching IF stage: issues one-cycle-latency imem reads under a credit limit,
// queues returned words, and kills everything buffered or in flight on a branch redirect.
module if_stage_prefetch #(
    parameter int                    WORD_WIDTH = if_stage_prefetch_pkg::WORD_WIDTH,
    parameter logic [WORD_WIDTH-1:0] ADDR_STEP  = WORD_WIDTH'(if_stage_prefetch_pkg::IF_ADDR_STEP),
    parameter logic [WORD_WIDTH-1:0] RESET_PC   = WORD_WIDTH'(if_stage_prefetch_pkg::IF_RESET_PC),
    parameter int                    FIFO_DEPTH = if_stage_prefetch_pkg::IF_FIFO_DEPTH
) (
    input logic                  clk,
    input logic                  rst,
    if_stage_prefetch_if.master  bus
);
    localparam int CW = if_stage_prefetch_pkg::count_width(FIFO_DEPTH);
    localparam int EW = 2 * WORD_WIDTH;

    logic [WORD_WIDTH-1:0] fetch_pc;
    logic [WORD_WIDTH-1:0] inflight_pc;
    logic                  inflight;
    logic                  issue;
    logic                  push;
    logic                  pop;
    logic                  out_valid;
    logic [CW-1:0]         count;
    logic [CW:0]           occupied;
    logic [EW-1:0]         push_data;
    logic [EW-1:0]         head_data;

    // The in-flight read already owns a slot, so a returning word always finds room.
    assign occupied  = {1'b0, count} + {{CW{1'b0}}, inflight};
    assign issue     = rst && !bus.Branch_Taken && (occupied < (CW+1)'(FIFO_DEPTH));
    assign push      = rst && inflight && !bus.Branch_Taken;
    assign out_valid = rst && (count != '0);
    assign pop       = out_valid && !bus.Freeze && !bus.Branch_Taken;
    assign push_data = {inflight_pc + ADDR_STEP, bus.imem_rdata};

    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_pc <= fetch_pc;
            end
            if (bus.Branch_Taken) begin
                fetch_pc <= bus.Branch_Address;
            end else if (issue) begin
                fetch_pc <= fetch_pc + ADDR_STEP;
            end
        end
    end

    fetch_fifo #(
        .ENTRY_W (EW),
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (bus.Branch_Taken),
        .push      (push),
        .pop       (pop),
        .push_data (push_data),
        .head_data (head_data),
        .count     (count)
    );

    assign bus.imem_req     = issue;
    assign bus.imem_addr    = fetch_pc;
    assign bus.out_valid    = out_valid;
    assign bus.PC_Stage_out = out_valid ? head_data[EW-1:WORD_WIDTH] : '0;
    assign bus.instruction  = out_valid ? head_data[WORD_WIDTH-1:0]  : '0;
    assign bus.fifo_count   = rst ? count : '0;

endmodule

// File: tb/tb_if_stage_prefetch.sv
// Directed bench for if_stage_prefetch: fill, freeze, redirects, address wrap and mid-stream reset.
module tb_if_stage_prefetch;
    localparam int W = 32;
    localparam int D = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_asserts = 0;
    int   n_fail    = 0;

    always #5 clk = ~clk;

    if_stage_prefetch_if #(.WORD_WIDTH(W), .FIFO_DEPTH(D)) bus_a ();
    if_stage_prefetch_if #(.WORD_WIDTH(W), .FIFO_DEPTH(D)) bus_b ();

    if_stage_prefetch #(
        .WORD_WIDTH (W),
        .ADDR_STEP  (32'd1),
        .RESET_PC   (32'd0),
        .FIFO_DEPTH (D)
    ) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    if_stage_prefetch #(
        .WORD_WIDTH (W),
        .ADDR_STEP  (32'd4),
        .RESET_PC   (32'hFFFF_FFF8),
        .FIFO_DEPTH (D)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    // Instruction memories: word at address a is 0x1000+a (dut_a) / 0x2000+a (dut_b), one cycle later.
    always @(posedge clk) begin
        bus_a.imem_rdata <= 32'h1000 + bus_a.imem_addr;
        bus_b.imem_rdata <= 32'h2000 + bus_b.imem_addr;
    end

    always @(negedge clk) begin
        n_asserts++;
        assert (!(dut_a.push && dut_a.u_fifo.count == 3'(D)) && bus_a.fifo_count <= 3'(D))
        else begin
            n_fail++;
            $error("FAIL overflow: push=%0b count=%0d limit=%0d", dut_a.push, dut_a.u_fifo.count, D);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        rst                 = 1'b0;
        bus_a.Branch_Taken  = 1'b0;
        bus_a.Freeze        = 1'b0;
        #1;
        chk("rst_req",   32'(bus_a.imem_req),   32'd0);
        chk("rst_valid", 32'(bus_a.out_valid),  32'd0);
        chk("rst_count", 32'(bus_a.fifo_count), 32'd0);
        step();
        step();
    endtask

    initial begin
        bus_a.Freeze         = 1'b0;
        bus_a.Branch_Taken   = 1'b0;
        bus_a.Branch_Address = '0;
        bus_b.Freeze         = 1'b0;
        bus_b.Branch_Taken   = 1'b0;
        bus_b.Branch_Address = '0;

        // Streaming fill, plus the wrapping instance alongside.
        do_reset();
        step();
        rst = 1'b1;
        #1;
        for (int c = 0; c < 8; c++) begin
            if (c != 0) begin
                step();
                #1;
            end
            chk("t1_req",  32'(bus_a.imem_req), 32'd1);
            chk("t1_addr", bus_a.imem_addr,     32'(c));
            if (c < 2) begin
                chk("t1_valid_fill", 32'(bus_a.out_valid), 32'd0);
            end else begin
                chk("t1_valid", 32'(bus_a.out_valid),  32'd1);
                chk("t1_pc",    bus_a.PC_Stage_out,    32'(c - 1));
                chk("t1_instr", bus_a.instruction,     32'h1000 + 32'(c - 2));
                chk("t1_count", 32'(bus_a.fifo_count), 32'd1);
            end
            if (c < 3) begin
                chk("wrap_addr", bus_b.imem_addr, 32'hFFFF_FFF8 + 32'(4 * c));
            end
            if (c >= 2 && c < 5) begin
                chk("wrap_pc", bus_b.PC_Stage_out, 32'hFFFF_FFFC + 32'(4 * (c - 2)));
            end
        end

        // Freeze from release: FIFO fills to 4, head holds, then drains in order.
        do_reset();
        step();
        rst          = 1'b1;
        bus_a.Freeze = 1'b1;
        #1;
        for (int c = 0; c < 10; c++) begin
            if (c != 0) begin
                step();
                #1;
            end
            if (c < 4) begin
                chk("frz_req",  32'(bus_a.imem_req), 32'd1);
                chk("frz_addr", bus_a.imem_addr,     32'(c));
            end else begin
                chk("frz_req_stop", 32'(bus_a.imem_req), 32'd0);
            end
            if (c == 4) begin
                chk("frz_count3", 32'(bus_a.fifo_count), 32'd3);
            end
            if (c >= 5) begin
                chk("frz_count4", 32'(bus_a.fifo_count), 32'd4);
                chk("frz_pc",     bus_a.PC_Stage_out,    32'd1);
                chk("frz_instr",  bus_a.instruction,     32'h1000);
            end
        end
        step();
        bus_a.Freeze = 1'b0;
        #1;
        for (int k = 0; k < 8; k++) begin
            if (k != 0) begin
                step();
                #1;
            end
            chk("drain_valid", 32'(bus_a.out_valid), 32'd1);
            chk("drain_pc",    bus_a.PC_Stage_out,   32'(k + 1));
            chk("drain_instr", bus_a.instruction,    32'h1000 + 32'(k));
            if (k == 1) begin
                chk("drain_req",  32'(bus_a.imem_req), 32'd1);
                chk("drain_addr", bus_a.imem_addr,     32'd4);
            end
        end

        // Redirect with 3 buffered entries and one read in flight.
        do_reset();
        step();
        rst          = 1'b1;
        bus_a.Freeze = 1'b1;
        #1;
        step();
        step();
        step();
        step();
        chk("br_pre_count", 32'(bus_a.fifo_count), 32'd3);
        bus_a.Branch_Taken   = 1'b1;
        bus_a.Branch_Address = 32'h40;
        #1;
        chk("br_req_kill", 32'(bus_a.imem_req), 32'd0);
        step();
        bus_a.Branch_Taken = 1'b0;
        bus_a.Freeze       = 1'b0;
        #1;
        chk("br_t1_count", 32'(bus_a.fifo_count), 32'd0);
        chk("br_t1_valid", 32'(bus_a.out_valid),  32'd0);
        chk("br_t1_req",   32'(bus_a.imem_req),   32'd1);
        chk("br_t1_addr",  bus_a.imem_addr,       32'h40);
        step();
        chk("br_t2_valid", 32'(bus_a.out_valid),  32'd0);
        chk("br_t2_count", 32'(bus_a.fifo_count), 32'd0);
        chk("br_t2_addr",  bus_a.imem_addr,       32'h41);
        step();
        chk("br_t3_valid", 32'(bus_a.out_valid), 32'd1);
        chk("br_t3_pc",    bus_a.PC_Stage_out,   32'h41);
        chk("br_t3_instr", bus_a.instruction,    32'h1040);
        step();
        chk("br_t4_pc",    bus_a.PC_Stage_out,   32'h42);
        chk("br_t4_instr", bus_a.instruction,    32'h1041);

        // Back-to-back redirects: only the second target survives.
        do_reset();
        step();
        rst = 1'b1;
        #1;
        step();
        step();
        step();
        bus_a.Branch_Taken   = 1'b1;
        bus_a.Branch_Address = 32'h80;
        #1;
        chk("bb_req_kill1", 32'(bus_a.imem_req), 32'd0);
        step();
        bus_a.Branch_Address = 32'h90;
        #1;
        chk("bb_req_kill2", 32'(bus_a.imem_req),   32'd0);
        chk("bb_valid",     32'(bus_a.out_valid),  32'd0);
        chk("bb_count",     32'(bus_a.fifo_count), 32'd0);
        step();
        bus_a.Branch_Taken = 1'b0;
        #1;
        chk("bb_t1_addr",  bus_a.imem_addr,      32'h90);
        chk("bb_t1_valid", 32'(bus_a.out_valid), 32'd0);
        step();
        chk("bb_t2_addr",  bus_a.imem_addr,      32'h91);
        chk("bb_t2_valid", 32'(bus_a.out_valid), 32'd0);
        step();
        chk("bb_t3_pc",    bus_a.PC_Stage_out,   32'h91);
        chk("bb_t3_instr", bus_a.instruction,    32'h1090);
        step();
        chk("bb_t4_pc",    bus_a.PC_Stage_out,   32'h92);
        chk("bb_t4_instr", bus_a.instruction,    32'h1091);

        // One-cycle reset in the middle of traffic with a wandering Freeze.
        do_reset();
        step();
        rst = 1'b1;
        #1;
        for (int c = 0; c < 8; c++) begin
            step();
            bus_a.Freeze = 1'($urandom_range(0, 1));
        end
        step();
        rst          = 1'b0;
        bus_a.Freeze = 1'($urandom_range(0, 1));
        #1;
        chk("mr_in_req",   32'(bus_a.imem_req),   32'd0);
        chk("mr_in_valid", 32'(bus_a.out_valid),  32'd0);
        chk("mr_in_count", 32'(bus_a.fifo_count), 32'd0);
        step();
        rst          = 1'b1;
        bus_a.Freeze = 1'($urandom_range(0, 1));
        #1;
        chk("mr_t1_valid", 32'(bus_a.out_valid),  32'd0);
        chk("mr_t1_count", 32'(bus_a.fifo_count), 32'd0);
        chk("mr_t1_req",   32'(bus_a.imem_req),   32'd1);
        chk("mr_t1_addr",  bus_a.imem_addr,       32'd0);
        step();
        bus_a.Freeze = 1'($urandom_range(0, 1));
        #1;
        chk("mr_t2_valid", 32'(bus_a.out_valid), 32'd0);
        chk("mr_t2_addr",  bus_a.imem_addr,      32'd1);
        step();
        bus_a.Freeze = 1'($urandom_range(0, 1));
        #1;
        chk("mr_t3_valid", 32'(bus_a.out_valid), 32'd1);
        chk("mr_t3_pc",    bus_a.PC_Stage_out,   32'd1);
        chk("mr_t3_instr", bus_a.instruction,    32'h1000);

        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/if_stage_prefetch.md
Name: if_stage_prefetch

Overview:
- Parametrised successor to the single-register fetch stage.
- Drives a synchronous instruction memory with one-cycle read latency and buffers fetched words in a prefetch FIFO.
- Presents {next-PC, instruction} pairs to ID with a valid/stall handshake.
- Branch redirect flushes all buffered and in-flight fetches. Sits between the PC/redirect logic of EXE and the IF/ID pipeline register.

Parameters:
- WORD_WIDTH, 32, width of PC, addresses and instructions (from the shared constants header).
- ADDR_STEP, 1, PC increment per fetched instruction (1 = word-addressed memory, 4 = byte-addressed).
- RESET_PC, 0, first fetch address after reset.
- FIFO_DEPTH, 4, prefetch FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-low (0 = reset).
- Freeze  input  1  ID stall; while 1, no entry is popped.
- Branch_Taken  input  1  redirect request from EXE.
- Branch_Address  input  WORD_WIDTH  redirect target.
- imem_req  output  1  read request to instruction memory this cycle.
- imem_addr  output  WORD_WIDTH  read address; meaningful only when imem_req=1.
- imem_rdata  input  WORD_WIDTH  read data; valid exactly one cycle after the request.
- out_valid  output  1  FIFO head holds a valid entry.
- PC_Stage_out  output  WORD_WIDTH  head entry's fetch address + ADDR_STEP.
- instruction  output  WORD_WIDTH  head entry's instruction word.
- fifo_count  output  log2(FIFO_DEPTH)+1  occupied FIFO entries.

Behaviour:
- Reset (rst=0 at clock edge):
  - fetch_pc=RESET_PC; FIFO empty; in-flight flag cleared.
  - While rst=0: imem_req=0, out_valid=0, fifo_count=0.
- Issue:
  - imem_req=1 iff rst=1, Branch_Taken=0 and fifo_count + inflight < FIFO_DEPTH.
  - imem_addr=fetch_pc.
  - On issue: fetch_pc <= fetch_pc + ADDR_STEP, modulo 2^WORD_WIDTH (wraps silently). Otherwise fetch_pc holds.
- In-flight tracking:
  - Issue sets inflight=1 and latches inflight_pc=imem_addr for the next cycle.
  - In that next cycle {inflight_pc + ADDR_STEP, imem_rdata} is pushed at the closing edge, unless killed by Branch_Taken in that same cycle.
- Credit rule: issue counts the in-flight slot, so a push never finds the FIFO full. Overflow is impossible by construction; verification asserts it.
- Pop: occurs when out_valid=1, Freeze=0 and Branch_Taken=0. Head advances at the edge.
- Push and pop in the same cycle: fifo_count unchanged. Pointers wrap modulo FIFO_DEPTH.
- Outputs:
  - out_valid = (fifo_count != 0).
  - PC_Stage_out and instruction show the head entry, forced to 0 when out_valid=0.
  - No bypass: a word returned in cycle N is visible at the FIFO head in N+1 at the earliest.
- Branch_Taken=1 in cycle T (highest priority):
  - imem_req=0 in T; no pop in T.
  - At the T edge: FIFO emptied, in-flight response discarded, fetch_pc <= Branch_Address.
  - T+1: req at Branch_Address (out_valid=0).
  - T+2: rdata returned and pushed.
  - T+3: out_valid=1 with PC_Stage_out = Branch_Address + ADDR_STEP.
- Back-to-back Branch_Taken: the last one wins; each cancels the previous target's fetches.
- Freeze=1 with FIFO full: issue stops; the head stays stable; no entry is lost or duplicated.
- Reset mid-operation: overrides everything including Branch_Taken. Any in-flight response is discarded.
- Steady state with Freeze=0: one instruction per cycle after the initial 2-cycle fill latency.

Decomposition:
- WORD_WIDTH stays in the shared constants header.
- Add to the shared header:
  - IF_FIFO_DEPTH default.
  - IF_ADDR_STEP default.
  - IF_RESET_PC default.
- Sub-module fetch_fifo holds the parametrised synchronous FIFO:
  - Entry width 2*WORD_WIDTH.
  - Ports: push, pop, flush, count, head data.
  - Flush has priority over push and pop.
- Issue/credit/epoch logic stays in if_stage_prefetch.

Test Plan:
- Reset then release, memory returns 0x1000+addr, Freeze=0 -> imem_addr 0,1,2,… from the first cycle; out_valid from cycle 2; PC_Stage_out 1,2,3,…; instruction 0x1000,0x1001,…; one per cycle.
- Freeze=1 for 10 cycles after fill, DEPTH=4 -> imem_req drops once count+inflight=4; fifo_count=4; head stays PC_Stage_out=1; on release, outputs 1..8 in order with no gaps or duplicates.
- Branch_Taken with Branch_Address=0x40 while the FIFO holds 3 entries and a request is in flight -> next cycle count=0 and imem_addr=0x40; stale data never appears; out_valid returns 3 cycles after the branch with PC_Stage_out=0x41.
- Branch_Taken in consecutive cycles with targets 0x80 then 0x90 -> only the 0x90 stream (PC_Stage_out 0x91,…) reaches the output.
- ADDR_STEP=4, RESET_PC=0xFFFFFFF8 -> fetch addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0; PC_Stage_out 0xFFFFFFFC, 0x0, 0x4 (wrap).
- Assert rst=0 for one cycle mid-stream with Freeze toggling randomly -> out_valid=0 and fifo_count=0 on the next cycle; the next fetch is at RESET_PC; the overflow assertion never fires.
